// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: countdown, timed play, strike scoring and mole pacing.
// Defining WHACK_PAUSE_EN adds a pause input and the PAUSED state.
module whack_game_ctrl #(
  parameter int unsigned TICK_CYCLES       = 100000000,
  parameter int unsigned COUNTDOWN_SECONDS = 3,
  parameter int unsigned GAME_SECONDS      = 30,
  parameter int unsigned MOLE_PERIOD_INIT  = 100000000,
  parameter int unsigned MOLE_PERIOD_MIN   = 25000000,
  parameter int unsigned SPEEDUP_STEP      = 5000000,
  parameter int unsigned MISS_LIMIT        = 5,
  parameter int unsigned SCORE_W           = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         hit_btn,
  input  logic [4:0]         mole_position,
`ifdef WHACK_PAUSE_EN
  input  logic               pause,
`endif
  output logic               gen_enable,
  output logic               gen_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         time_left,
  output logic [3:0]         misses,
  output logic [2:0]         state,
  output logic               game_over
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned PMAX = (MOLE_PERIOD_MIN + SPEEDUP_STEP > MOLE_PERIOD_INIT) ?
                                 (MOLE_PERIOD_MIN + SPEEDUP_STEP) : MOLE_PERIOD_INIT;
  localparam int unsigned PW = $clog2(PMAX + 1);

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PERIOD_INIT = PW'(MOLE_PERIOD_INIT);
  localparam logic [PW-1:0] PERIOD_MIN  = PW'(MOLE_PERIOD_MIN);
  localparam logic [PW-1:0] PERIOD_STEP = PW'(SPEEDUP_STEP);
  localparam logic [PW-1:0] PERIOD_KNEE = PW'(MOLE_PERIOD_MIN + SPEEDUP_STEP);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_OVER      = 3'd3,
    S_PAUSED    = 3'd4
  } state_t;

  state_t               state_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [PW-1:0]        mole_cnt_q;
  logic [PW-1:0]        period_q;
  logic [SCORE_W-1:0]   score_q;
  logic [3:0]           misses_q;
  logic [7:0]           time_left_q;
  logic                 gen_pulse_q;
  logic                 lock_q;

  logic                 pause_req;
  logic                 tick;
  logic                 final_tick;
  logic                 mole_expire;
  logic                 strike;
  logic                 hit_ok;
  logic                 miss;
  logic                 miss_end;
  logic                 advance;
  logic [SCORE_W-1:0]   score_d;
  logic [3:0]           misses_d;
  logic [PW-1:0]        period_d;

  always_comb begin
`ifdef WHACK_PAUSE_EN
    pause_req = pause;
`else
    pause_req = 1'b0;
`endif
    tick        = (tick_cnt_q == TICK_LAST);
    final_tick  = tick && (time_left_q == 8'd1);
    mole_expire = (mole_cnt_q == '0);
    strike      = (state_q == S_PLAY) && !pause_req && (hit_btn != '0) && !gen_pulse_q && !lock_q;
    hit_ok      = strike && ((hit_btn & mole_position) != '0) && ((hit_btn & ~mole_position) == '0);
    miss        = strike && !hit_ok;
    score_d     = (&score_q) ? score_q : score_q + 1'b1;
    misses_d    = (&misses_q) ? misses_q : misses_q + 4'd1;
    period_d    = (period_q >= PERIOD_KNEE) ? period_q - PERIOD_STEP : PERIOD_MIN;
    miss_end    = miss && (misses_d == 4'(MISS_LIMIT));
    // The pause-entry edge freezes and the resume edge runs, so a pause shifts time by its length.
    advance     = ((state_q == S_PLAY) && !pause_req) || ((state_q == S_PAUSED) && pause_req);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      mole_cnt_q  <= '0;
      period_q    <= PERIOD_INIT;
      score_q     <= '0;
      misses_q    <= '0;
      time_left_q <= '0;
      gen_pulse_q <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      gen_pulse_q <= 1'b0;
      if (gen_pulse_q) lock_q <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q     <= S_COUNTDOWN;
            score_q     <= '0;
            misses_q    <= '0;
            period_q    <= PERIOD_INIT;
            time_left_q <= 8'(COUNTDOWN_SECONDS);
            tick_cnt_q  <= '0;
            lock_q      <= 1'b0;
          end
        end
        S_COUNTDOWN: begin
          tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
          if (tick) begin
            if (time_left_q == 8'd1) begin
              state_q     <= S_PLAY;
              time_left_q <= 8'(GAME_SECONDS);
              gen_pulse_q <= 1'b1;
              mole_cnt_q  <= period_q - 1'b1;
            end else begin
              time_left_q <= time_left_q - 8'd1;
            end
          end
        end
        S_PLAY, S_PAUSED: begin
          if (advance) begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            if (tick) time_left_q <= time_left_q - 8'd1;
            if (hit_ok) begin
              score_q     <= score_d;
              period_q    <= period_d;
              mole_cnt_q  <= period_d - 1'b1;
              gen_pulse_q <= 1'b1;
              lock_q      <= 1'b1;
            end else if (mole_expire) begin
              mole_cnt_q  <= period_q - 1'b1;
              gen_pulse_q <= 1'b1;
            end else begin
              mole_cnt_q  <= mole_cnt_q - 1'b1;
            end
            if (miss) misses_q <= misses_d;
            if (final_tick || miss_end) begin
              state_q     <= S_OVER;
              gen_pulse_q <= 1'b0;
            end else if (state_q == S_PAUSED) begin
              state_q <= S_PLAY;
            end
          end else if (state_q == S_PLAY) begin
            if (final_tick) begin
              state_q     <= S_OVER;
              time_left_q <= '0;
              tick_cnt_q  <= '0;
            end else begin
              state_q <= S_PAUSED;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    gen_enable = (state_q == S_PLAY) || (state_q == S_PAUSED);
    game_over  = (state_q == S_OVER);
    gen_pulse  = gen_pulse_q;
    score      = score_q;
    time_left  = time_left_q;
    misses     = misses_q;
    state      = state_q;
  end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed table-driven bench for whack_game_ctrl using small timing parameters.
module tb_whack_game_ctrl;

  localparam int unsigned SCORE_W = 10;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [4:0]         hit_btn;
  logic [4:0]         mole_position;
`ifdef WHACK_PAUSE_EN
  logic               pause;
`endif
  logic               gen_enable;
  logic               gen_pulse;
  logic [SCORE_W-1:0] score;
  logic [7:0]         time_left;
  logic [3:0]         misses;
  logic [2:0]         state;
  logic               game_over;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  whack_game_ctrl #(
    .TICK_CYCLES      (10),
    .COUNTDOWN_SECONDS(2),
    .GAME_SECONDS     (5),
    .MOLE_PERIOD_INIT (8),
    .MOLE_PERIOD_MIN  (4),
    .SPEEDUP_STEP     (2),
    .MISS_LIMIT       (3),
    .SCORE_W          (SCORE_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .hit_btn      (hit_btn),
    .mole_position(mole_position),
`ifdef WHACK_PAUSE_EN
    .pause        (pause),
`endif
    .gen_enable   (gen_enable),
    .gen_pulse    (gen_pulse),
    .score        (score),
    .time_left    (time_left),
    .misses       (misses),
    .state        (state),
    .game_over    (game_over)
  );

  typedef struct {
    int         adv;
    logic       st_in;
    logic [4:0] hit;
    logic [4:0] mole;
    logic [2:0] e_state;
    int         e_tl;
    int         e_score;
    int         e_miss;
    logic       e_pulse;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int adv, logic s, logic [4:0] h, logic [4:0] m,
                              logic [2:0] st, int tl, int sc, int ms, logic gp);
    vec_t v;
    v.adv = adv; v.st_in = s; v.hit = h; v.mole = m;
    v.e_state = st; v.e_tl = tl; v.e_score = sc; v.e_miss = ms; v.e_pulse = gp;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [2:0] st, input int tl,
                         input int sc, input int ms, input logic gp);
    chk({tag, ".state"},     idx, 32'(state), 32'(st));
    chk({tag, ".time_left"}, idx, 32'(time_left), 32'(tl));
    chk({tag, ".score"},     idx, 32'(score), 32'(sc));
    chk({tag, ".misses"},    idx, 32'(misses), 32'(ms));
    chk({tag, ".gen_pulse"}, idx, 32'(gen_pulse), 32'(gp));
    chk({tag, ".gen_enable"}, idx, 32'(gen_enable), 32'((st == 3'd2) || (st == 3'd4)));
    chk({tag, ".game_over"}, idx, 32'(game_over), 32'(st == 3'd3));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    start   = 1'b0;
    hit_btn = '0;
`ifdef WHACK_PAUSE_EN
    pause   = 1'b0;
`endif
  endtask

  initial begin
    logic [4:0] M;
    logic [4:0] N;
    M = 5'b00100;
    N = 5'b00010;

    // Scenario A: countdown, idle play to time-out, restart, ignored inputs in countdown.
    tv.push_back(mk(1,  1, 5'b0, 5'b0, 3'd1, 2, 0, 0, 0));
    tv.push_back(mk(19, 0, 5'b0, 5'b0, 3'd1, 1, 0, 0, 0));
    tv.push_back(mk(1,  0, 5'b0, 5'b0, 3'd2, 5, 0, 0, 1));
    tv.push_back(mk(1,  0, 5'b0, 5'b0, 3'd2, 5, 0, 0, 0));
    tv.push_back(mk(7,  0, 5'b0, 5'b0, 3'd2, 5, 0, 0, 1));
    tv.push_back(mk(1,  0, 5'b0, 5'b0, 3'd2, 5, 0, 0, 0));
    tv.push_back(mk(1,  0, 5'b0, 5'b0, 3'd2, 4, 0, 0, 0));
    tv.push_back(mk(6,  0, 5'b0, 5'b0, 3'd2, 4, 0, 0, 1));
    tv.push_back(mk(33, 0, 5'b0, 5'b0, 3'd2, 1, 0, 0, 0));
    tv.push_back(mk(1,  0, 5'b0, 5'b0, 3'd3, 0, 0, 0, 0));
    tv.push_back(mk(5,  0, 5'b0, 5'b0, 3'd3, 0, 0, 0, 0));
    tv.push_back(mk(1,  1, 5'b0, 5'b0, 3'd1, 2, 0, 0, 0));
    tv.push_back(mk(1,  1, 5'b0, 5'b0, 3'd1, 2, 0, 0, 0));
    tv.push_back(mk(1,  0, 5'b00001, 5'b00001, 3'd1, 2, 0, 0, 0));
    // Scenario B: hits, speed-up to the floor, ignored strikes, misses up to the limit.
    tv.push_back(mk(18, 0, 5'b0, M, 3'd2, 5, 0, 0, 1));
    tv.push_back(mk(2,  0, M,    M, 3'd2, 5, 1, 0, 1));
    tv.push_back(mk(1,  0, 5'b0, M, 3'd2, 5, 1, 0, 0));
    tv.push_back(mk(5,  0, 5'b0, M, 3'd2, 5, 1, 0, 1));
    tv.push_back(mk(6,  0, 5'b0, M, 3'd2, 4, 1, 0, 1));
    tv.push_back(mk(1,  0, 5'b00001, M, 3'd2, 4, 1, 0, 0));
    tv.push_back(mk(1,  0, M,    M, 3'd2, 4, 2, 0, 1));
    tv.push_back(mk(1,  0, M,    M, 3'd2, 4, 2, 0, 0));
    tv.push_back(mk(1,  0, M,    M, 3'd2, 4, 3, 0, 1));
    tv.push_back(mk(4,  0, 5'b0, M, 3'd2, 3, 3, 0, 1));
    tv.push_back(mk(4,  0, M,    M, 3'd2, 3, 4, 0, 1));
    tv.push_back(mk(1,  0, 5'b0, M, 3'd2, 3, 4, 0, 0));
    tv.push_back(mk(3,  0, 5'b0, M, 3'd2, 2, 4, 0, 1));
    tv.push_back(mk(2,  0, 5'b00110, M, 3'd2, 2, 4, 1, 0));
    tv.push_back(mk(1,  0, 5'b00001, M, 3'd2, 2, 4, 2, 0));
    tv.push_back(mk(1,  0, 5'b00100, 5'b00000, 3'd3, 2, 4, 3, 0));
    tv.push_back(mk(3,  0, 5'b0, M, 3'd3, 2, 4, 3, 0));
    tv.push_back(mk(1,  1, 5'b0, M, 3'd1, 2, 0, 0, 0));
    // Scenario C: hit on the final tick is scored and ends the game without a pulse.
    tv.push_back(mk(20, 0, 5'b0, N, 3'd2, 5, 0, 0, 1));
    tv.push_back(mk(49, 0, 5'b0, N, 3'd2, 1, 0, 0, 0));
    tv.push_back(mk(1,  0, N,    N, 3'd3, 0, 1, 0, 0));

    reset = 1'b0;
    start = 1'b0;
    hit_btn = '0;
    mole_position = '0;
`ifdef WHACK_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 0, 3'd0, 0, 0, 0, 1'b0);
    reset = 1'b1;

    foreach (tv[i]) begin
      mole_position = tv[i].mole;
      for (int k = 0; k < tv[i].adv; k++) begin
        if (k == tv[i].adv - 1) begin
          start   = tv[i].st_in;
          hit_btn = tv[i].hit;
        end
        step();
      end
      chk_all("vec", i, tv[i].e_state, tv[i].e_tl, tv[i].e_score, tv[i].e_miss, tv[i].e_pulse);
    end

    // Asynchronous reset in the middle of play with score 2.
    start = 1'b1;
    step();
    repeat (20) step();
    chk_all("mid", 0, 3'd2, 5, 0, 0, 1'b1);
    mole_position = 5'b00001;
    step();
    hit_btn = 5'b00001;
    step();
    step();
    hit_btn = 5'b00001;
    step();
    chk_all("mid", 1, 3'd2, 5, 2, 0, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 0, 3'd0, 0, 0, 0, 1'b0);
    step();
    chk_all("async_rst", 1, 3'd0, 0, 0, 0, 1'b0);
    reset = 1'b1;

`ifdef WHACK_PAUSE_EN
    // Seven cycles in PAUSED delay the mole pulse and the second tick by seven cycles.
    start = 1'b1;
    step();
    repeat (20) step();
    chk_all("pause", 0, 3'd2, 5, 0, 0, 1'b1);
    step();
    pause = 1'b1;
    step();
    chk_all("pause", 1, 3'd4, 5, 0, 0, 1'b0);
    repeat (2) step();
    hit_btn = 5'b00001;
    step();
    chk_all("pause", 2, 3'd4, 5, 0, 0, 1'b0);
    repeat (3) step();
    chk_all("pause", 3, 3'd4, 5, 0, 0, 1'b0);
    pause = 1'b1;
    step();
    chk_all("pause", 4, 3'd2, 5, 0, 0, 1'b0);
    repeat (5) step();
    chk_all("pause", 5, 3'd2, 5, 0, 0, 1'b0);
    step();
    chk_all("pause", 6, 3'd2, 5, 0, 0, 1'b1);
    step();
    chk_all("pause", 7, 3'd2, 5, 0, 0, 1'b0);
    step();
    chk_all("pause", 8, 3'd2, 4, 0, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
